// File: rtl/pwm_ramp_master_pkg.sv
// pwm_ramp_master shared definitions: PWM register map, duty limits and
// the ramp FSM state encoding.
package pwm_ramp_master_pkg;

    localparam logic [12:0] FREQ1 = 13'h0020;
    localparam logic [12:0] FREQ2 = 13'h0024;
    localparam logic [12:0] FREQ3 = 13'h0028;
    localparam logic [12:0] FREQ4 = 13'h002C;
    localparam logic [12:0] DUTY1 = 13'h0030;
    localparam logic [12:0] DUTY2 = 13'h0034;
    localparam logic [12:0] DUTY3 = 13'h0038;
    localparam logic [12:0] DUTY4 = 13'h003C;

    localparam int          DUTY_W   = 7;
    localparam logic [6:0]  DUTY_MAX = 7'd100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WAIT,
        S_WR,
        S_VFY,
        S_FIN
    } state_t;

    function automatic logic [12:0] duty_addr(input logic [1:0] ch);
        return DUTY1 + {9'b0, ch, 2'b00};
    endfunction

endpackage

// File: rtl/pwm_ramp_master.sv
// Ramps one PWM duty register toward a target, one +/-1 write per interval.
// Define PWM_RAMP_READBACK_EN to verify each write with a readback.
module pwm_ramp_master #(
    parameter int STEP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        chan_sel,
    input  logic [6:0]        target,
    input  logic [STEP_W-1:0] step_div,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ena,
    output logic [3:0]        wea,
    output logic [12:0]       addr,
    output logic [31:0]       din,
    input  logic [31:0]       dout
);
    import pwm_ramp_master_pkg::*;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_ena;
    logic [3:0]          r_wea;
    logic [12:0]         r_addr;
    logic [31:0]         r_din;
    logic [DUTY_W-1:0]   r_cur;
    logic [DUTY_W-1:0]   r_nxt;
    logic [DUTY_W-1:0]   r_tgt;
    logic [STEP_W-1:0]   r_div;
    logic [STEP_W-1:0]   r_cnt;
    logic [24:0]         w_unused_dout;

    assign w_unused_dout = dout[31:7];

`ifdef PWM_RAMP_READBACK_EN
    logic r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign ena  = r_ena;
    assign wea  = r_wea;
    assign addr = r_addr;
    assign din  = r_din;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ena   <= 1'b0;
            r_wea   <= 4'h0;
            r_addr  <= 13'h0;
            r_din   <= 32'h0;
            r_cur   <= '0;
            r_nxt   <= '0;
            r_tgt   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
`ifdef PWM_RAMP_READBACK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE && r_state != S_FIN) begin
                // a write already on the bus lands; the ramp stops there
                if (r_state == S_WR)
                    r_cur <= r_nxt;
                r_ena   <= 1'b0;
                r_wea   <= 4'h0;
                r_done  <= 1'b1;
                r_state <= S_FIN;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_tgt   <= (target > DUTY_MAX) ? DUTY_MAX
                                                           : target;
                            r_div   <= (step_div == '0) ? STEP_W'(1)
                                                        : step_div;
                            r_addr  <= duty_addr(chan_sel);
                            r_busy  <= 1'b1;
                            r_ena   <= 1'b1;
                            r_wea   <= 4'h0;
`ifdef PWM_RAMP_READBACK_EN
                            r_err   <= 1'b0;
`endif
                            r_state <= S_RD;
                        end
                    end
                    S_RD: begin
                        r_cur   <= dout[DUTY_W-1:0];
                        r_ena   <= 1'b0;
                        r_state <= S_CMP;
                    end
                    S_CMP: begin
                        if (r_cur == r_tgt) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_nxt   <= (r_cur < r_tgt) ? r_cur + 7'd1
                                                       : r_cur - 7'd1;
                            r_cnt   <= r_div - STEP_W'(1);
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt == '0) begin
                            r_ena   <= 1'b1;
                            r_wea   <= 4'hF;
                            r_din   <= {25'b0, r_nxt};
                            r_state <= S_WR;
                        end else begin
                            r_cnt <= r_cnt - STEP_W'(1);
                        end
                    end
                    S_WR: begin
                        r_cur <= r_nxt;
                        r_wea <= 4'h0;
`ifdef PWM_RAMP_READBACK_EN
                        r_state <= S_VFY;
`else
                        r_ena   <= 1'b0;
                        r_state <= S_CMP;
`endif
                    end
`ifdef PWM_RAMP_READBACK_EN
                    S_VFY: begin
                        r_ena <= 1'b0;
                        if (dout[DUTY_W-1:0] != r_nxt) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_CMP;
                        end
                    end
`endif
                    S_FIN: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_master.sv
// Self-checking bench for pwm_ramp_master with a behavioural PWM register
// slave and a write scoreboard.
module tb_pwm_ramp_master;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  chan_sel;
    logic [6:0]  target;
    logic [15:0] step_div;
    logic        busy;
    logic        done;
    logic        err;
    logic        ena;
    logic [3:0]  wea;
    logic [12:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

`ifdef PWM_RAMP_READBACK_EN
    localparam int VF = 1;
`else
    localparam int VF = 0;
`endif

    typedef struct {
        logic [12:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          wr_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] mem[0:15];
    logic        force_zero;

    pwm_ramp_master #(.STEP_W(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .chan_sel (chan_sel),
        .target   (target),
        .step_div (step_div),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ena      (ena),
        .wea      (wea),
        .addr     (addr),
        .din      (din),
        .dout     (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // behavioural register slave: duty/freq words at addr[5:2]
    assign dout = (force_zero && addr == 13'h0034) ? 32'd0 : mem[addr[5:2]];

    always @(posedge clock)
        if (ena && wea == 4'hF)
            mem[addr[5:2]] <= din;

    // write scoreboard
    always @(negedge clock) begin
        if (reset && ena && wea != 4'h0) begin
            n_cmp++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr=%h din=%0d wea=%h",
                         addr, din, wea);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({addr, din, wea} !== {e.a, e.d, 4'hF}) begin
                    n_bad++;
                    $display("FAIL wr_data: got addr=%h din=%0d wea=%h, want addr=%h din=%0d wea=f",
                             addr, din, wea, e.a, e.d);
                end
            end
        end
    end

    task automatic push_wr(input logic [12:0] a, input int v);
        wr_t e;
        e.a = a;
        e.d = 32'(v);
        exp_q.push_back(e);
    endtask

    task automatic run_cmd(input logic [1:0] ch, input logic [6:0] tg,
                           input logic [15:0] dv, output int lat,
                           output logic b1, output logic e1);
        @(negedge clock);
        chan_sel = ch;
        target   = tg;
        step_div = dv;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        b1    = busy;
        e1    = ena;
        lat   = 1;
        while (done !== 1'b1 && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        if (done !== 1'b1)
            lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({busy, done, err, ena, wea, addr, din} !== 53'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {busy, done, err, ena, wea, addr, din});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ramp_up();
        int   lat;
        logic b1, e1;
        wr_cyc.delete();
        for (int v = 1; v <= 3; v++) push_wr(13'h0030, v);
        run_cmd(2'd0, 7'd3, 16'd2, lat, b1, e1);
        n_cmp++;
        if ({b1, e1} !== 2'b11) begin
            n_bad++;
            $display("FAIL up_busy_rd: got busy,ena=%b, want 11", {b1, e1});
        end
        n_cmp++;
        if (lat !== 3 * (2 + 2 + VF) + 3) begin
            n_bad++;
            $display("FAIL up_latency: got %0d, want %0d", lat, 3 * (4 + VF) + 3);
        end
        n_cmp++;
        if (wr_cyc.size() != 3 || wr_cyc[1] - wr_cyc[0] != 4 + VF
            || wr_cyc[2] - wr_cyc[1] != 4 + VF) begin
            n_bad++;
            $display("FAIL up_spacing: got %0d writes, want 3 spaced %0d",
                     wr_cyc.size(), 4 + VF);
        end
        @(negedge clock);
        n_cmp++;
        if ({busy, done, mem[12]} !== {2'b00, 32'd3}) begin
            n_bad++;
            $display("FAIL up_final: got busy=%b done=%b duty=%0d, want 0 0 3",
                     busy, done, mem[12]);
        end
    endtask

    task automatic test_ramp_down();
        int   lat;
        logic b1, e1;
        mem[14] <= 32'd5;
        for (int v = 4; v >= 2; v--) push_wr(13'h0038, v);
        run_cmd(2'd2, 7'd2, 16'd1, lat, b1, e1);
        n_cmp++;
        if (lat !== 3 * (1 + 2 + VF) + 3) begin
            n_bad++;
            $display("FAIL down_latency: got %0d, want %0d", lat, 3 * (3 + VF) + 3);
        end
        @(negedge clock);
        n_cmp++;
        if (mem[14] !== 32'd2 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL down_final: got duty=%0d pending=%0d, want 2 0",
                     mem[14], exp_q.size());
        end
    endtask

    task automatic test_clip_zero_step();
        int   lat;
        logic b1, e1;
        for (int v = 1; v <= 100; v++) push_wr(13'h0034, v);
        run_cmd(2'd1, 7'd120, 16'd0, lat, b1, e1);
        n_cmp++;
        if (lat !== 100 * (1 + 2 + VF) + 3) begin
            n_bad++;
            $display("FAIL clip_latency: got %0d, want %0d", lat, 100 * (3 + VF) + 3);
        end
        @(negedge clock);
        n_cmp++;
        if (mem[13] !== 32'd100) begin
            n_bad++;
            $display("FAIL clip_duty: got %0d, want 100", mem[13]);
        end
        run_cmd(2'd1, 7'd120, 16'd4, lat, b1, e1);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL zero_step_latency: got %0d, want 3", lat);
        end
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL zero_step_idle: got busy=%b pending=%0d, want 0 0",
                     busy, exp_q.size());
        end
    endtask

    task automatic test_busy_abort();
        int n;
        push_wr(13'h003C, 1);
        push_wr(13'h003C, 2);
        @(negedge clock);
        chan_sel = 2'd3;
        target   = 7'd10;
        step_div = 16'd5;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (mem[15] !== 32'd2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        n_cmp++;
        if (mem[15] !== 32'd2) begin
            n_bad++;
            $display("FAIL abort_reach: got duty=%0d, want 2", mem[15]);
        end
        chan_sel = 2'd0;
        target   = 7'd0;
        start    = 1'b1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy: got %b, want 1", busy);
        end
        @(negedge clock);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_cmp++;
        if ({done, ena} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_done: got done,ena=%b, want 10", {done, ena});
        end
        @(negedge clock);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_idle: got busy,done=%b, want 00", {busy, done});
        end
        repeat (20) @(negedge clock);
        n_cmp++;
        if (mem[15] !== 32'd2 || mem[12] !== 32'd3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_held: got duty3=%0d duty0=%0d pending=%0d, want 2 3 0",
                     mem[15], mem[12], exp_q.size());
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clock);
        chan_sel = 2'd0;
        target   = 7'd9;
        step_div = 16'd1;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if ({busy, ena, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL start_abort_idle: got busy,ena,done=%b, want 000",
                     {busy, ena, done});
        end
        repeat (3) @(negedge clock);
    endtask

`ifdef PWM_RAMP_READBACK_EN
    task automatic test_readback();
        int   lat;
        logic b1, e1;
        force_zero = 1'b1;
        push_wr(13'h0034, 1);
        run_cmd(2'd1, 7'd50, 16'd1, lat, b1, e1);
        n_cmp++;
        if (lat !== 6 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL rb_err: got lat=%0d err=%b, want 6 1", lat, err);
        end
        @(negedge clock);
        n_cmp++;
        if ({busy, err} !== 2'b01) begin
            n_bad++;
            $display("FAIL rb_idle: got busy,err=%b, want 01", {busy, err});
        end
        force_zero = 1'b0;
        run_cmd(2'd1, 7'd1, 16'd1, lat, b1, e1);
        n_cmp++;
        if (lat !== 3 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rb_clear: got lat=%0d err=%b, want 3 0", lat, err);
        end
        @(negedge clock);
    endtask
`endif

    task automatic test_reset_mid();
        int   n;
        int   lat;
        logic b1, e1;
        push_wr(13'h0030, 4);
        @(negedge clock);
        chan_sel = 2'd0;
        target   = 7'd6;
        step_div = 16'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(ena && wea == 4'hF) && n < 100) begin
            @(negedge clock);
            n++;
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, ena, wea, addr, din} !== 53'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h, want 0",
                     {busy, done, err, ena, wea, addr, din});
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        n_cmp++;
        if (mem[12] !== 32'd3) begin
            n_bad++;
            $display("FAIL reset_mid_duty: got %0d, want 3", mem[12]);
        end
        push_wr(13'h0030, 4);
        run_cmd(2'd0, 7'd4, 16'd1, lat, b1, e1);
        n_cmp++;
        if (lat !== 1 * (1 + 2 + VF) + 3) begin
            n_bad++;
            $display("FAIL reset_resume: got %0d, want %0d", lat, 3 + VF + 3);
        end
        @(negedge clock);
        n_cmp++;
        if (mem[12] !== 32'd4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_resume_duty: got duty=%0d pending=%0d, want 4 0",
                     mem[12], exp_q.size());
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        chan_sel   = 2'd0;
        target     = 7'd0;
        step_div   = 16'd0;
        force_zero = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clip_zero_step();
        test_busy_abort();
        test_start_abort_idle();
`ifdef PWM_RAMP_READBACK_EN
        test_readback();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
